// File: rtl/core_run_sequencer.sv
// Host-side sequencer for the core req/done handshake: launches NUM_RUNS runs, times each one,
// aborts runs after TIMEOUT cycles. Optional total_cycles output under SEQ_TOTAL_CYCLES_EN.
module core_run_sequencer #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned TIMEOUT    = 4095,
    parameter int unsigned NUM_RUNS   = 3,
    parameter int unsigned REQ_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             core_done,
    output logic             core_req,
    output logic             busy,
    output logic [3:0]       run_idx,
    output logic             result_valid,
    output logic [CNT_W-1:0] cycle_count,
    output logic             timeout_err,
`ifdef SEQ_TOTAL_CYCLES_EN
    output logic [CNT_W+3:0] total_cycles,
`endif
    output logic             seq_done
);

    localparam int unsigned REQ_W = (REQ_CYCLES > 1) ? $clog2(REQ_CYCLES) : 1;
    localparam logic [REQ_W-1:0] REQ_LAST = REQ_W'(REQ_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [3:0] LAST_RUN = 4'(NUM_RUNS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAssert,
        StArm,
        StWaitDone,
        StPost,
        StFinish
    } state_e;

    state_e           state_q, state_d;
    logic [REQ_W-1:0] req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       run_idx_q, run_idx_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic             timeout_err_q, timeout_err_d;
    logic             core_req_q, core_req_d;
    logic             busy_q, busy_d;
    logic             result_valid_q, result_valid_d;
    logic             seq_done_q, seq_done_d;
`ifdef SEQ_TOTAL_CYCLES_EN
    logic [CNT_W+3:0] total_q, total_d;
`endif

    // Counts WAIT_DONE cycles inclusively, so a done seen in the first WAIT_DONE cycle reports 1.
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        req_cnt_d     = req_cnt_q;
        cnt_d         = cnt_q;
        run_idx_d     = run_idx_q;
        cycle_count_d = cycle_count_q;
        timeout_err_d = timeout_err_q;
`ifdef SEQ_TOTAL_CYCLES_EN
        total_d       = total_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d       = StAssert;
                    run_idx_d     = 4'd0;
                    timeout_err_d = 1'b0;
                    req_cnt_d     = '0;
`ifdef SEQ_TOTAL_CYCLES_EN
                    total_d       = '0;
`endif
                end
            end
            StAssert: begin
                if (req_cnt_q == REQ_LAST) begin
                    state_d = StArm;
                end else begin
                    req_cnt_d = req_cnt_q + REQ_W'(1);
                end
            end
            StArm: begin
                // A done still high from the previous run must drop before timing starts.
                if (!core_done) begin
                    state_d = StWaitDone;
                    cnt_d   = '0;
                end
            end
            StWaitDone: begin
                cnt_d = cnt_inc;
                if (core_done) begin
                    state_d       = StPost;
                    cycle_count_d = cnt_inc;
                end else if (cnt_inc == TIMEOUT_C) begin
                    state_d       = StPost;
                    cycle_count_d = TIMEOUT_C;
                    timeout_err_d = 1'b1;
                end
            end
            StPost: begin
`ifdef SEQ_TOTAL_CYCLES_EN
                total_d = total_q + {4'd0, cycle_count_q};
`endif
                if (run_idx_q == LAST_RUN) begin
                    state_d = StFinish;
                end else begin
                    state_d   = StAssert;
                    run_idx_d = run_idx_q + 4'd1;
                    req_cnt_d = '0;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Status outputs are registered decodes of the next state.
        core_req_d     = (state_d == StAssert);
        busy_d         = (state_d != StIdle);
        result_valid_d = (state_d == StPost);
        seq_done_d     = (state_d == StFinish);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            req_cnt_q      <= '0;
            cnt_q          <= '0;
            run_idx_q      <= 4'd0;
            cycle_count_q  <= '0;
            timeout_err_q  <= 1'b0;
            core_req_q     <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            seq_done_q     <= 1'b0;
`ifdef SEQ_TOTAL_CYCLES_EN
            total_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            req_cnt_q      <= req_cnt_d;
            cnt_q          <= cnt_d;
            run_idx_q      <= run_idx_d;
            cycle_count_q  <= cycle_count_d;
            timeout_err_q  <= timeout_err_d;
            core_req_q     <= core_req_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            seq_done_q     <= seq_done_d;
`ifdef SEQ_TOTAL_CYCLES_EN
            total_q        <= total_d;
`endif
        end
    end

    assign core_req     = core_req_q;
    assign busy         = busy_q;
    assign run_idx      = run_idx_q;
    assign result_valid = result_valid_q;
    assign cycle_count  = cycle_count_q;
    assign timeout_err  = timeout_err_q;
    assign seq_done     = seq_done_q;
`ifdef SEQ_TOTAL_CYCLES_EN
    assign total_cycles = total_q;
`endif

endmodule

// File: tb/tb_core_run_sequencer.sv
// Bench for core_run_sequencer: a core model replays per-run stale/done delays and each result
// is checked against expected counts derived from the delay table.
module tb_core_run_sequencer;

    localparam int unsigned CNT_W      = 16;
    localparam int unsigned TIMEOUT    = 15;
    localparam int unsigned NUM_RUNS   = 3;
    localparam int unsigned REQ_CYCLES = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             core_done;
    logic             core_req;
    logic             busy;
    logic [3:0]       run_idx;
    logic             result_valid;
    logic [CNT_W-1:0] cycle_count;
    logic             timeout_err;
    logic             seq_done;
`ifdef SEQ_TOTAL_CYCLES_EN
    logic [CNT_W+3:0] total_cycles;
`endif

    core_run_sequencer #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .NUM_RUNS   (NUM_RUNS),
        .REQ_CYCLES (REQ_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .core_done    (core_done),
        .core_req     (core_req),
        .busy         (busy),
        .run_idx      (run_idx),
        .result_valid (result_valid),
        .cycle_count  (cycle_count),
        .timeout_err  (timeout_err),
`ifdef SEQ_TOTAL_CYCLES_EN
        .total_cycles (total_cycles),
`endif
        .seq_done     (seq_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Per run: s = cycles done stays high after req falls, d = cycles after that until done
    // rises (0 = never).
    int s_arr [NUM_RUNS];
    int d_arr [NUM_RUNS];

    int mr = 0;
    bit model_en = 1'b0;
    bit active = 1'b0;
    bit req_prev = 1'b0;
    int ph = 0;
    int cur_s = 0;
    int cur_d = 0;
    int req_len = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit times_out(input int d);
        return (d == 0) || (d > int'(TIMEOUT));
    endfunction

    // Core model and req-width monitor, evaluated just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (model_en) begin
            if (req_prev && !core_req) begin
                chk("req_width", req_len, REQ_CYCLES);
                req_len = 0;
                ph = 0;
                active = 1'b1;
                cur_s = (mr < int'(NUM_RUNS)) ? s_arr[mr] : 0;
                cur_d = (mr < int'(NUM_RUNS)) ? d_arr[mr] : 0;
                mr++;
            end else if (active) begin
                ph++;
            end
            if (core_req) req_len++;
            if (active) begin
                if (ph < cur_s) core_done = 1'b1;
                else if (cur_d != 0 && ph >= cur_s + cur_d) core_done = 1'b1;
                else core_done = 1'b0;
            end
        end
        req_prev = core_req;
    end

    task automatic check_zero(input string tag);
        chk({tag, "_req"}, core_req, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_idx"}, run_idx, 0);
        chk({tag, "_rv"}, result_valid, 0);
        chk({tag, "_cnt"}, cycle_count, 0);
        chk({tag, "_terr"}, timeout_err, 0);
        chk({tag, "_sdone"}, seq_done, 0);
`ifdef SEQ_TOTAL_CYCLES_EN
        chk({tag, "_total"}, total_cycles, 0);
`endif
    endtask

    task automatic run_seq(input bit poke);
        int exp_cnt [NUM_RUNS];
        bit exp_to [NUM_RUNS];
        int posts = 0;
        int cyc = 0;
        int last_post = -1;
        int done_cyc = -1;
        bit any_to = 1'b0;
        int tot = 0;
        for (int i = 0; i < int'(NUM_RUNS); i++) begin
            exp_to[i]  = times_out(d_arr[i]);
            exp_cnt[i] = exp_to[i] ? int'(TIMEOUT) : d_arr[i];
        end
        mr = 0;
        active = 1'b0;
        req_len = 0;
        model_en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_to_req", core_req, 1);
        while (done_cyc < 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = (poke && (cyc == 5 || cyc == 40)) ? 1'b1 : 1'b0;
            if (result_valid) begin
                if (posts < int'(NUM_RUNS)) begin
                    any_to = any_to | exp_to[posts];
                    tot += exp_cnt[posts];
                    chk("post_count", cycle_count, exp_cnt[posts]);
                    chk("post_idx", run_idx, posts);
                    chk("post_terr", timeout_err, any_to);
                end
                posts++;
                last_post = cyc;
            end
            if (seq_done) done_cyc = cyc;
        end
        start = 1'b0;
        chk("seq_done_seen", done_cyc >= 0, 1);
        chk("num_posts", posts, NUM_RUNS);
        chk("seq_done_lat", done_cyc - last_post, 1);
        chk("final_terr", timeout_err, any_to);
`ifdef SEQ_TOTAL_CYCLES_EN
        chk("total", total_cycles, tot);
`endif
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_sdone", seq_done, 0);
        chk("idle_idx_hold", run_idx, NUM_RUNS - 1);
        chk("idle_cnt_hold", cycle_count, exp_cnt[NUM_RUNS-1]);
        chk("idle_terr_hold", timeout_err, any_to);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int waited;
        reset = 1'b1;
        start = 1'b0;
        core_done = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("idle_no_start", busy, 0);

        // Nominal 10/20/30.
        s_arr = '{0, 0, 0};
        d_arr = '{10, 20, 30};
        run_seq(1'b0);

        // Stale done held 5 cycles, then done 7 cycles after it drops.
        s_arr = '{5, 5, 5};
        d_arr = '{7, 7, 7};
        run_seq(1'b0);

        // Run 1 never completes.
        s_arr = '{0, 0, 0};
        d_arr = '{4, 0, 4};
        run_seq(1'b0);

        // Done on the timeout cycle, and one cycle too late.
        s_arr = '{0, 2, 0};
        d_arr = '{int'(TIMEOUT), int'(TIMEOUT), int'(TIMEOUT) + 1};
        run_seq(1'b0);

        // Start pulses while busy must be ignored.
        s_arr = '{1, 0, 3};
        d_arr = '{6, 9, 12};
        run_seq(1'b1);

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < int'(NUM_RUNS); i++) begin
                s_arr[i] = int'($urandom_range(0, 3));
                d_arr[i] = int'($urandom_range(0, 20));
            end
            run_seq(k[0]);
        end

        // Reset during WAIT_DONE of run 1, after run 0 timed out.
        s_arr = '{0, 0, 0};
        d_arr = '{0, 0, 5};
        mr = 0;
        active = 1'b0;
        req_len = 0;
        model_en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (mr < 2 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("reach_run1", mr >= 2, 1);
        repeat (3) @(negedge clk);
        chk("pre_reset_terr", timeout_err, 1);
        reset = 1'b1;
        model_en = 1'b0;
        core_done = 1'b0;
        @(negedge clk);
        check_zero("mid_reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_idle", busy, 0);

        s_arr = '{0, 1, 0};
        d_arr = '{3, 8, 0};
        run_seq(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/core_run_sequencer.md
Name: core_run_sequencer

Overview:
- Host-side initiator for the processor core's req/done handshake. Launches NUM_RUNS program runs back-to-back by driving core req, waits for core done, and measures each run's cycle count.
- Enforces a timeout on every run and reports per-run results and overall completion to the testbench or host.
- Sits between the host/testbench and the top-level core's req and done pins.

Parameters:
- CNT_W, 16, width of the cycle counters and the cycle_count output.
- TIMEOUT, 4095, maximum WAIT_DONE cycles before a run is aborted; must be less than 2^CNT_W.
- NUM_RUNS, 3, runs per start command; range 1..15.
- REQ_CYCLES, 2, cycles req is held high per run; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- core_done  in  1  done from core, level, 1 = program finished.
- core_req  out  1  request to core.
- busy  out  1  high in any state other than IDLE.
- run_idx  out  4  index of the current or last run, 0-based.
- result_valid  out  1  one-cycle pulse when a run's result is posted.
- cycle_count  out  CNT_W  cycles from first WAIT_DONE cycle to done seen; saturates at TIMEOUT.
- timeout_err  out  1  sticky; set if any run in the sequence timed out.
- seq_done  out  1  one-cycle pulse when all runs are complete.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters 0.
- Reset has priority over every other input in every state, including mid-run; the next cycle is IDLE with all outputs 0.
- IDLE:
  - start=1 → ASSERT; run_idx←0, timeout_err←0, req counter←0.
  - start=0 → stay in IDLE.
  - start is ignored in all other states.
- ASSERT:
  - core_req=1 (registered); high for exactly REQ_CYCLES consecutive cycles.
  - Then → ARM.
- ARM:
  - core_req=0.
  - core_done=0 → WAIT_DONE; cycle counter←0.
  - core_done=1 → stay in ARM. This protects against a stale done from the previous run.
  - ARM has no timeout.
- WAIT_DONE:
  - core_req=0; cycle counter increments each cycle.
  - core_done=1 → POST with cycle_count←counter value.
  - If counter==TIMEOUT with core_done still 0 → POST with cycle_count←TIMEOUT and timeout_err←1.
  - If done and the timeout condition occur in the same cycle, done wins and no error is flagged.
- POST:
  - result_valid=1 for exactly one cycle; cycle_count and run_idx are stable from this cycle until the next POST.
  - If run_idx==NUM_RUNS-1 → FINISH; otherwise run_idx←run_idx+1 and → ASSERT.
- FINISH:
  - seq_done=1 for one cycle, then → IDLE.
  - run_idx, cycle_count and timeout_err hold their values in IDLE until the next start.
- Latency:
  - start to first core_req: 1 cycle.
  - core_done high to result_valid: 1 cycle.
- The counter never wraps because it stops at TIMEOUT.
- A timed-out run does not stop the sequence; subsequent runs still execute.

Optional Feature:
- Macro: SEQ_TOTAL_CYCLES_EN.
- Defined:
  - Adds output total_cycles, width CNT_W+4.
  - Cleared on start in IDLE; adds each posted cycle_count in POST.
  - Valid and stable from the seq_done pulse until the next start.
  - Reset value 0.
- Undefined:
  - Port and adder are absent.
  - All other behaviour is identical.

Test Plan:
- Nominal, NUM_RUNS=3: pulse start; the core model raises done 10, 20 and 30 cycles after each req falls → three result_valid pulses with cycle_count 10/20/30 and run_idx 0/1/2; timeout_err=0; seq_done one cycle after the third POST. With SEQ_TOTAL_CYCLES_EN, total_cycles=60.
- Stale done: core_done held high for 5 cycles after req falls, then low, then high 7 cycles later → sequencer waits in ARM; cycle_count=7.
- Timeout, TIMEOUT=15: done never rises on run 1; runs 0 and 2 finish at 4 cycles → run 1 posts cycle_count=15; timeout_err=1 and stays 1; seq_done still pulses.
- Done/timeout tie: done rises exactly at counter==TIMEOUT → cycle_count=TIMEOUT; timeout_err=0.
- Reset mid-run: assert reset in WAIT_DONE of run 1 → next cycle all outputs 0 and state IDLE; a later start restarts at run_idx=0.
- Start ignored: pulse start while busy=1 → no change to run_idx or sequence timing; core_req is high for exactly REQ_CYCLES=2 cycles per run.
